manchester_encode: RTL and testbench

//   PICC->PCD bit encoder: Manchester-codes a bit stream onto an fc/16 subcarrier.

---
 rtl/ISO14443A_pkg.sv | 33 +++
 rtl/picc_bit_timer.sv | 31 +++
 rtl/manchester_encode.sv | 75 +++++++
 tb/tb_manchester_encode.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ISO14443A_pkg.sv
// Shared types and defaults for the ISO14443A PICC transmit path.
package ISO14443A_pkg;

  localparam int unsigned PICC_BIT_TICKS       = 128;
  localparam int unsigned PICC_SUBCARRIER_HALF = 8;

  typedef enum logic [1:0] {
    PICCBitSequence_D,
    PICCBitSequence_E,
    PICCBitSequence_F
  } PICCBitSequence;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SOC,
    ST_DATA,
    ST_EOC
  } enc_state_e;

  // D modulates the first half of the bit period, E the second, F never.
  function automatic logic seq_mod(input PICCBitSequence seq, input logic sub,
                                   input logic first_half);
    logic m;
    m = 1'b0;
    case (seq)
      PICCBitSequence_D: m = sub & first_half;
      PICCBitSequence_E: m = sub & ~first_half;
      default:           m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/picc_bit_timer.sv
// Bit-period counter for the PICC encoder: phase within the bit and subcarrier phase.
module picc_bit_timer #(
  parameter int unsigned BIT_TICKS       = 128,
  parameter int unsigned SUBCARRIER_HALF = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic sub,
  output logic last_tick,
  output logic first_half
);

  localparam int CW      = $clog2(BIT_TICKS);
  localparam int SUB_BIT = $clog2(SUBCARRIER_HALF);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)         cnt <= '0;
    else if (clear)     cnt <= '0;
    else if (run)       cnt <= last_tick ? '0 : cnt + 1'b1;
  end

  assign last_tick  = (cnt == CW'(BIT_TICKS - 1));
  assign first_half = (cnt < CW'(BIT_TICKS / 2));
  // Half-period is a power of two, so the subcarrier phase is a single count bit.
  assign sub        = ~cnt[SUB_BIT];

endmodule

// File: rtl/manchester_encode.sv
// PICC->PCD Manchester bit encoder: SOC (D), one D/E per data bit, EOC (F).
module manchester_encode
  import ISO14443A_pkg::*;
#(
  parameter int unsigned BIT_TICKS       = PICC_BIT_TICKS,
  parameter int unsigned SUBCARRIER_HALF = PICC_SUBCARRIER_HALF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_data,
  output logic in_req,
  output logic lm_out,
  output logic busy
);

  enc_state_e     state;
  logic           bit_q;
  logic           sub, last_tick, first_half;
  logic           start;
  PICCBitSequence seq;

  assign start = (state == ST_IDLE) && in_valid;

  picc_bit_timer #(
    .BIT_TICKS      (BIT_TICKS),
    .SUBCARRIER_HALF(SUBCARRIER_HALF)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start),
    .run       (state != ST_IDLE),
    .sub       (sub),
    .last_tick (last_tick),
    .first_half(first_half)
  );

  always_comb begin
    seq = PICCBitSequence_F;
    case (state)
      ST_SOC:  seq = PICCBitSequence_D;
      ST_DATA: seq = bit_q ? PICCBitSequence_D : PICCBitSequence_E;
      default: seq = PICCBitSequence_F;
    endcase
  end

  // One request per bit period; the bit is taken on the same edge if in_valid is up.
  assign in_req = last_tick && ((state == ST_SOC) || (state == ST_DATA));
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      bit_q  <= 1'b0;
      lm_out <= 1'b0;
    end else begin
      lm_out <= seq_mod(seq, sub, first_half);
      case (state)
        ST_IDLE: if (in_valid) state <= ST_SOC;
        ST_SOC, ST_DATA:
          if (last_tick) begin
            if (in_valid) begin
              bit_q <= in_data;
              state <= ST_DATA;
            end else begin
              state <= ST_EOC;
            end
          end
        ST_EOC:  if (last_tick) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_manchester_encode.sv
// Directed and short random frames; a negedge monitor decodes lm_out into D/E/F.
module tb_manchester_encode;

  localparam int BT = 128;
  localparam int SH = 8;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_data = 1'b0;
  logic in_req, lm_out, busy;

  int errors = 0, checks = 0, cyc = 0;

  manchester_encode #(.BIT_TICKS(BT), .SUBCARRIER_HALF(SH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_req(in_req), .lm_out(lm_out), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: sim time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic string classify(input logic [BT-1:0] w);
    logic [BT-1:0] d, e;
    for (int i = 0; i < BT; i++) begin
      d[i] = (i < BT/2)  && ((i % (2*SH)) < SH);
      e[i] = (i >= BT/2) && ((i % (2*SH)) < SH);
    end
    if (w === d) return "D";
    if (w === e) return "E";
    if (w === '0) return "F";
    return "?";
  endfunction

  function automatic string exp_seq(input logic [127:0] b, input int n);
    string s;
    s = "D";
    for (int i = 0; i < n; i++) begin
      if (b[i]) s = {s, "D"};
      else      s = {s, "E"};
    end
    return {s, "F"};
  endfunction

  // lm_out sampled at frame sample t reflects counter tick t-1.
  logic          inframe = 1'b0;
  int            t, cur_len, cur_req, cur_reqbad, cur_start;
  logic [BT-1:0] win;
  string         cur_seq;
  string         q_seq[$];
  int            q_len[$], q_req[$], q_reqbad[$], q_start[$], q_end[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      inframe = 1'b0;
    end else if (!inframe) begin
      if (busy) begin
        inframe = 1'b1; t = 0; cur_seq = ""; cur_len = 1;
        cur_req = 0; cur_reqbad = 0; cur_start = cyc;
      end
    end else begin
      t++;
      win[(t-1) % BT] = lm_out;
      if (((t-1) % BT) == BT-1) cur_seq = {cur_seq, classify(win)};
      if (busy) cur_len++;
      if (in_req) begin
        cur_req++;
        if ((t % BT) != BT-1) cur_reqbad++;
      end
      if (!busy) begin
        inframe = 1'b0;
        q_seq.push_back(cur_seq); q_len.push_back(cur_len); q_req.push_back(cur_req);
        q_reqbad.push_back(cur_reqbad); q_start.push_back(cur_start); q_end.push_back(cyc);
      end
    end
  end

  task automatic clear_q();
    q_seq.delete(); q_len.delete(); q_req.delete();
    q_reqbad.delete(); q_start.delete(); q_end.delete();
  endtask

  task automatic pop_frame(output string s, output int len, output int req, output int reqbad,
                           output int st, output int en, output bit ok);
    ok = (q_seq.size() != 0);
    s = ""; len = 0; req = 0; reqbad = 0; st = 0; en = 0;
    if (ok) begin
      s = q_seq.pop_front(); len = q_len.pop_front(); req = q_req.pop_front();
      reqbad = q_reqbad.pop_front(); st = q_start.pop_front(); en = q_end.pop_front();
    end
  endtask

  // Source side: holds in_valid/in_data until in_req, then moves to the next bit.
  task automatic drive_frame(input logic [127:0] bits, input int n);
    int idx, guard;
    in_valid = 1'b1; in_data = bits[0]; idx = 0; guard = 0;
    while (!busy && guard < 20) begin @(negedge clk); guard++; end
    checks++;
    if (!busy) begin
      errors++; $display("FAIL frame_start: busy=%b required 1", busy);
      in_valid = 1'b0;
      return;
    end
    if (n == 0) in_valid = 1'b0;
    guard = 0;
    while (guard < (n + 4) * BT) begin
      @(negedge clk); guard++;
      if (!busy) break;
      if (in_req && in_valid) begin
        @(posedge clk); #1;
        idx++;
        if (idx < n) in_data = bits[idx];
        else         in_valid = 1'b0;
      end
    end
    checks++;
    if (busy) begin errors++; $display("FAIL frame_end: busy=%b required 0", busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (lm_out !== 1'b0) begin errors++; $display("FAIL reset_lm: got %b want 0", lm_out); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (in_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", in_req); end
    in_valid = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame_basic();
    string s; int len, req, rb, st, en; bit ok;
    clear_q();
    drive_frame(128'b1101, 4);
    @(posedge clk); #1;
    pop_frame(s, len, req, rb, st, en, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_frame: no frame seen"); end
    checks++; if (s != "DDEDDF") begin errors++; $display("FAIL basic_seq: got %s want DDEDDF", s); end
    checks++; if (len !== 768) begin errors++; $display("FAIL basic_busy: got %0d want 768", len); end
    checks++; if (req !== 5) begin errors++; $display("FAIL basic_req: got %0d want 5", req); end
    checks++; if (rb !== 0) begin errors++; $display("FAIL basic_req_spacing: got %0d off-slot want 0", rb); end
  endtask

  task automatic test_empty_frame();
    string s; int len, req, rb, st, en; bit ok;
    repeat (2) @(negedge clk);
    clear_q();
    drive_frame(128'b1, 0);
    @(posedge clk); #1;
    pop_frame(s, len, req, rb, st, en, ok);
    checks++; if (s != "DF") begin errors++; $display("FAIL empty_seq: got %s want DF", s); end
    checks++; if (len !== 256) begin errors++; $display("FAIL empty_busy: got %0d want 256", len); end
    checks++; if (req !== 1) begin errors++; $display("FAIL empty_req: got %0d want 1", req); end
  endtask

  task automatic test_seq_shape();
    int bad_d, bad_e, g, c;
    logic e;
    repeat (2) @(negedge clk);
    clear_q();
    bad_d = 0; bad_e = 0;
    fork
      drive_frame(128'b0, 1);
      begin
        g = 0;
        while (!busy && g < 20) begin @(negedge clk); g++; end
        for (int k = 1; k <= 2*BT; k++) begin
          @(negedge clk);
          if (k <= BT) begin
            c = k - 1;
            e = (c < 64) && ((c % 16) < 8);
            if (lm_out !== e) bad_d++;
          end else begin
            c = k - 1 - BT;
            e = (c >= 64) && ((c % 16) < 8);
            if (lm_out !== e) bad_e++;
          end
        end
      end
    join
    checks++; if (bad_d !== 0) begin errors++; $display("FAIL shape_D: got %0d bad cycles want 0", bad_d); end
    checks++; if (bad_e !== 0) begin errors++; $display("FAIL shape_E: got %0d bad cycles want 0", bad_e); end
    clear_q();
  endtask

  task automatic test_reset_mid();
    string s; int len, req, rb, st, en, g; bit ok;
    repeat (2) @(negedge clk);
    clear_q();
    fork
      drive_frame(128'hFF, 8);
      begin
        g = 0;
        while (!busy && g < 20) begin @(negedge clk); g++; end
        repeat (BT + 40) @(negedge clk);
        checks++; if (lm_out !== 1'b1) begin errors++; $display("FAIL pre_reset_lm: got %b want 1", lm_out); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (lm_out !== 1'b0) begin errors++; $display("FAIL midrst_lm: got %b want 0", lm_out); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (in_req !== 1'b0) begin errors++; $display("FAIL midrst_req: got %b want 0", in_req); end
      end
    join
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    clear_q();
    drive_frame(128'b1, 1);
    @(posedge clk); #1;
    pop_frame(s, len, req, rb, st, en, ok);
    checks++; if (s != "DDF") begin errors++; $display("FAIL post_rst_seq: got %s want DDF", s); end
    checks++; if (len !== 384) begin errors++; $display("FAIL post_rst_busy: got %0d want 384", len); end
  endtask

  task automatic test_back_to_back();
    string sa, sb; int la, ra, rba, sta, ena, lb, rb2, rbb, stb, enb; bit oka, okb;
    repeat (2) @(negedge clk);
    clear_q();
    drive_frame(128'b01, 2);
    drive_frame(128'b0, 1);
    @(posedge clk); #1;
    pop_frame(sa, la, ra, rba, sta, ena, oka);
    pop_frame(sb, lb, rb2, rbb, stb, enb, okb);
    checks++; if (sa != "DDEF") begin errors++; $display("FAIL b2b_seq_a: got %s want DDEF", sa); end
    checks++; if (la !== 512) begin errors++; $display("FAIL b2b_busy_a: got %0d want 512", la); end
    checks++; if (sb != "DEF") begin errors++; $display("FAIL b2b_seq_b: got %s want DEF", sb); end
    checks++; if (lb !== 384) begin errors++; $display("FAIL b2b_busy_b: got %0d want 384", lb); end
    checks++; if (stb - ena !== 1) begin errors++; $display("FAIL b2b_gap: got %0d want 1", stb - ena); end
  endtask

  task automatic test_random();
    string s, x; int len, req, rb, st, en, n; bit ok;
    logic [127:0] bits;
    for (int f = 0; f < 12; f++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      clear_q();
      n = $urandom_range(0, 12);
      bits = {$urandom, $urandom, $urandom, $urandom};
      x = exp_seq(bits, n);
      drive_frame(bits, n);
      @(posedge clk); #1;
      pop_frame(s, len, req, rb, st, en, ok);
      checks++; if (s != x) begin errors++; $display("FAIL rand_seq[%0d]: got %s want %s", f, s, x); end
      checks++; if (len !== (n + 2) * BT) begin errors++; $display("FAIL rand_busy[%0d]: got %0d want %0d", f, len, (n + 2) * BT); end
    end
  endtask

  initial begin
    test_reset();
    test_frame_basic();
    test_empty_frame();
    test_seq_shape();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
